// File: rtl/asic2_sha256_round_if.sv
// Serial word bus of the SHA-256 round engine: input words in, result words out.
// No handshake: the host drives in_w/in_var in step with the fixed 19-phase frame
// and reads out_var after the frame's output edges; nothing stalls or acknowledges.
interface asic2_sha256_round_if;
    logic [31:0] in_w;
    logic [31:0] in_var;
    logic [31:0] out_var;

    modport master (output in_w, output in_var, input out_var);
    modport slave  (input in_w, input in_var, output out_var);
endinterface

// File: rtl/asic2_sha256_round.sv
// One SHA-256 compression round with a fixed 19-phase serial frame:
// load W, K, A..H; compute the round; stream A'..H' out.
module asic2_sha256_round (
    input  logic                        clk,
    input  logic                        reset,
    asic2_sha256_round_if.slave         bus,
    output logic [4:0]                  dbg_phase
);

    logic [4:0]  phase_q, phase_d;
    logic [31:0] w_q, w_d, k_q, k_d, out_q, out_d;
    logic [31:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic [31:0] a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
    logic [31:0] s1, ch, s0, maj, t1, t2;

    assign s1  = {e_q[5:0], e_q[31:6]} ^ {e_q[10:0], e_q[31:11]} ^ {e_q[24:0], e_q[31:25]};
    assign ch  = (e_q & f_q) ^ (~e_q & g_q);
    assign s0  = {a_q[1:0], a_q[31:2]} ^ {a_q[12:0], a_q[31:13]} ^ {a_q[21:0], a_q[31:22]};
    assign maj = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
    assign t1  = h_q + s1 + ch + k_q + w_q;
    assign t2  = s0 + maj;

    always_comb begin
        phase_d = (phase_q == 5'd18) ? 5'd0 : phase_q + 5'd1;
        w_d = w_q;  k_d = k_q;  out_d = out_q;
        a_d = a_q;  b_d = b_q;  c_d = c_q;  d_d = d_q;
        e_d = e_q;  f_d = f_q;  g_d = g_q;  h_d = h_q;
        if (phase_q == 5'd0) begin
            w_d = bus.in_w;
        end else if (phase_q == 5'd1) begin
            k_d = bus.in_var;
        end else if (phase_q <= 5'd9) begin
            // Words enter at H and shift toward A, so the first loaded ends in A.
            a_d = b_q;  b_d = c_q;  c_d = d_q;  d_d = e_q;
            e_d = f_q;  f_d = g_q;  g_d = h_q;  h_d = bus.in_var;
        end else if (phase_q == 5'd10) begin
            a_d = t1 + t2;  b_d = a_q;  c_d = b_q;  d_d = c_q;
            e_d = d_q + t1; f_d = e_q;  g_d = f_q;  h_d = g_q;
        end else begin
            // Output phases reuse the shift chain: A leaves first, H last.
            out_d = a_q;
            a_d = b_q;  b_d = c_q;  c_d = d_q;  d_d = e_q;
            e_d = f_q;  f_d = g_q;  g_d = h_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 5'd0;
            w_q <= '0;  k_q <= '0;  out_q <= '0;
            a_q <= '0;  b_q <= '0;  c_q <= '0;  d_q <= '0;
            e_q <= '0;  f_q <= '0;  g_q <= '0;  h_q <= '0;
        end else begin
            phase_q <= phase_d;
            w_q <= w_d;  k_q <= k_d;  out_q <= out_d;
            a_q <= a_d;  b_q <= b_d;  c_q <= c_d;  d_q <= d_d;
            e_q <= e_d;  f_q <= f_d;  g_q <= g_d;  h_q <= h_d;
        end
    end

    assign bus.out_var = out_q;
    assign dbg_phase   = phase_q;

endmodule

// File: tb/tb_asic2_sha256_round.sv
// Self-checking bench for asic2_sha256_round: directed FIPS vectors plus random
// frames against a word-level reference of the SHA-256 round.
module tb_asic2_sha256_round;

    typedef logic [31:0] word8_t [8];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] dbg_phase;
    asic2_sha256_round_if bus ();

    asic2_sha256_round dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_phase (dbg_phase)
    );

    always #5 clk = ~clk;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_out = '0;
    word8_t      got_words;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference round: the textbook SHA-256 step on the eight working words.
    function automatic void sha_model(input logic [31:0] w, input logic [31:0] k,
                                      input word8_t v, output word8_t r);
        logic [31:0] s1, ch, s0, mj, t1, t2;
        s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
        ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
        s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
        mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
        t1 = v[7] + s1 + ch + k + w;
        t2 = s0 + mj;
        r[0] = t1 + t2;
        for (int i = 1; i < 8; i++) r[i] = v[i-1];
        r[4] = v[3] + t1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_out", bus.out_var, 32'h0);
        check("reset_phase", {27'b0, dbg_phase}, 32'd0);
        reset = 1'b0;
        last_out = '0;
    endtask

    // Drives one frame; abort_at < 19 asserts reset on that phase's edge instead.
    task automatic run_frame(input logic [31:0] w, input logic [31:0] k, input word8_t iv,
                             input word8_t expv, input bit junk, input int abort_at);
        int oi;
        oi = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(expv[i]);
        for (int p = 0; p < 19; p++) begin
            @(negedge clk);
            check("phase", {27'b0, dbg_phase}, p);
            bus.in_w   = junk ? $urandom : 32'h0;
            bus.in_var = junk ? $urandom : 32'h0;
            if (p == 0) bus.in_w = w;
            if (p == 1) bus.in_var = k;
            if (p >= 2 && p <= 9) bus.in_var = iv[p-2];
            if (p == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                check("midreset_out", bus.out_var, 32'h0);
                check("midreset_phase", {27'b0, dbg_phase}, 32'd0);
                reset = 1'b0;
                last_out = '0;
                exp_q.delete();
                return;
            end
            @(posedge clk); #1;
            if (p >= 11) begin
                last_out = exp_q.pop_front();
                got_words[oi] = bus.out_var;
                oi++;
                check("out_word", bus.out_var, last_out);
            end else begin
                check("out_hold", bus.out_var, last_out);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        word8_t zero8, iv, fips, r;
        logic [31:0] s2_diff, w, k;
        zero8 = '{default: 32'h0};
        iv    = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        fips  = '{32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                  32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};
        bus.in_w = '0;
        bus.in_var = '0;

        // Reset then an all-zero frame.
        do_reset();
        run_frame(32'h0, 32'h0, zero8, zero8, 1'b0, 99);

        // FIPS round 0 of "abc".
        run_frame(32'h61626380, 32'h428a2f98, iv, fips, 1'b0, 99);
        s2_diff = got_words[0] - got_words[4];

        // Same IV, different W and K=0; T2-derived difference must match.
        sha_model(32'h02000000, 32'h0, iv, r);
        run_frame(32'h02000000, 32'h0, iv, r, 1'b0, 99);
        check("s3_diff", got_words[0] - got_words[4], s2_diff);

        // Mid-frame reset at phase 5, then a clean FIPS frame.
        run_frame(32'h61626380, 32'h428a2f98, iv, fips, 1'b0, 5);
        run_frame(32'h61626380, 32'h428a2f98, iv, fips, 1'b0, 99);

        // Junk on ignored inputs must not disturb the result.
        run_frame(32'h61626380, 32'h428a2f98, iv, fips, 1'b1, 99);

        // Back-to-back frames: holds 1f83d9ab through the next load phases.
        run_frame(32'h61626380, 32'h428a2f98, iv, fips, 1'b0, 99);
        run_frame(32'h61626380, 32'h428a2f98, iv, fips, 1'b0, 99);

        // Random frames against the reference round.
        for (int n = 0; n < 20; n++) begin
            w = $urandom;
            k = $urandom;
            for (int i = 0; i < 8; i++) iv[i] = $urandom;
            sha_model(w, k, iv, r);
            run_frame(w, k, iv, r, $urandom_range(0, 1) == 1, 99);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
